// File: rtl/svm_feeder.sv
// rtl/svm_feeder.sv - quantising feature feeder with credit-limited classifier issue and ordered result queue
//
// Ports:
//   clk, rst (async, active-low)
//   in_valid / in_ready / in_x0 / in_x1 : Q7.4 feature pairs from upstream
//   x0 / x1                              : registered Q5.2 features to classifier (0 when idle)
//   label                                : classifier result, sampled LAT edges after issue
//   out_valid / out_ready / out_label / out_sat : ordered results to downstream
module svm_feeder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] in_x0,
    input  logic [11:0] in_x1,
    output logic [6:0]  x0,
    output logic [6:0]  x1,
    input  logic        label,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_label,
    output logic        out_sat
);

    localparam int IN_DEPTH  = 4;
    localparam int RES_DEPTH = 8;
    localparam int LAT       = 4;

    // Returns {clip, q[6:0]}: round-to-nearest Q7.4 -> Q5.2 with saturation.
    function automatic logic [7:0] quant(input logic [11:0] v);
        logic [10:0] sh;
        sh = 11'(({v[11], v} + 13'd2) >> 2);
        if (sh[10:6] == 5'b00000 || sh[10:6] == 5'b11111)
            quant = {1'b0, sh[6:0]};
        else if (sh[10])
            quant = {1'b1, 7'b1000000};
        else
            quant = {1'b1, 7'b0111111};
    endfunction

    // Input FIFO entry: {sat, q0, q1}
    logic [14:0] in_mem_q [IN_DEPTH];
    logic [14:0] in_mem_d [IN_DEPTH];
    logic [1:0]  in_wr_q, in_wr_d, in_rd_q, in_rd_d;
    logic [2:0]  in_cnt_q, in_cnt_d;
    logic        in_ready_q, in_ready_d;

    logic [6:0]  x0_q, x0_d, x1_q, x1_d;
    logic [LAT-1:0] v_q, v_d, s_q, s_d;

    // Result FIFO entry: {label, sat}
    logic [1:0]  res_mem_q [RES_DEPTH];
    logic [1:0]  res_mem_d [RES_DEPTH];
    logic [2:0]  res_wr_q, res_wr_d, res_rd_q, res_rd_d;
    logic [3:0]  res_cnt_q, res_cnt_d;

    logic        in_push, issue, capture, out_pop;
    logic [2:0]  inflight;
    logic [4:0]  credit_used;
    logic [7:0]  q0, q1;
    logic [14:0] head;

    always_comb begin
        in_push     = in_valid && in_ready_q;
        inflight    = 3'(v_q[0]) + 3'(v_q[1]) + 3'(v_q[2]) + 3'(v_q[3]);
        credit_used = {2'b00, inflight} + {1'b0, res_cnt_q};
        // Credits count both in-flight and queued results so a capture
        // always finds room; a same-cycle pop is deliberately not credited.
        issue       = (in_cnt_q != 3'd0) && (credit_used < 5'(RES_DEPTH));
        capture     = v_q[LAT-1];
        out_pop     = (res_cnt_q != 4'd0) && out_ready;

        q0   = quant(in_x0);
        q1   = quant(in_x1);
        head = in_mem_q[in_rd_q];

        in_mem_d = in_mem_q;
        if (in_push)
            in_mem_d[in_wr_q] = {q0[7] | q1[7], q0[6:0], q1[6:0]};
        in_wr_d    = in_wr_q + 2'(in_push);
        in_rd_d    = in_rd_q + 2'(issue);
        in_cnt_d   = in_cnt_q + 3'(in_push) - 3'(issue);
        in_ready_d = (in_cnt_d != 3'(IN_DEPTH));

        x0_d = issue ? head[13:7] : 7'd0;
        x1_d = issue ? head[6:0]  : 7'd0;
        v_d  = {v_q[LAT-2:0], issue};
        s_d  = {s_q[LAT-2:0], issue & head[14]};

        res_mem_d = res_mem_q;
        if (capture)
            res_mem_d[res_wr_q] = {label, s_q[LAT-1]};
        res_wr_d  = res_wr_q + 3'(capture);
        res_rd_d  = res_rd_q + 3'(out_pop);
        res_cnt_d = res_cnt_q + 4'(capture) - 4'(out_pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_mem_q   <= '{default: '0};
            in_wr_q    <= '0;
            in_rd_q    <= '0;
            in_cnt_q   <= '0;
            in_ready_q <= 1'b0;
            x0_q       <= '0;
            x1_q       <= '0;
            v_q        <= '0;
            s_q        <= '0;
            res_mem_q  <= '{default: '0};
            res_wr_q   <= '0;
            res_rd_q   <= '0;
            res_cnt_q  <= '0;
        end else begin
            in_mem_q   <= in_mem_d;
            in_wr_q    <= in_wr_d;
            in_rd_q    <= in_rd_d;
            in_cnt_q   <= in_cnt_d;
            in_ready_q <= in_ready_d;
            x0_q       <= x0_d;
            x1_q       <= x1_d;
            v_q        <= v_d;
            s_q        <= s_d;
            res_mem_q  <= res_mem_d;
            res_wr_q   <= res_wr_d;
            res_rd_q   <= res_rd_d;
            res_cnt_q  <= res_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign x0        = x0_q;
    assign x1        = x1_q;
    assign out_valid = (res_cnt_q != 4'd0);
    // Gate with out_valid so stale storage never shows after reset or drain.
    assign out_label = out_valid & res_mem_q[res_rd_q][1];
    assign out_sat   = out_valid & res_mem_q[res_rd_q][0];

endmodule

// File: tb/tb_svm_feeder.sv
// tb/tb_svm_feeder.sv - randomized scoreboard bench for svm_feeder
module tb_svm_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_x0, in_x1;
    logic [6:0]  x0, x1;
    logic        label = 1'b0;
    logic        out_valid;
    logic        out_ready;
    logic        out_label;
    logic        out_sat;

    always #5 clk = ~clk;

    svm_feeder dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x0(in_x0), .in_x1(in_x1),
        .x0(x0), .x1(x1),
        .label(label),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_label(out_label), .out_sat(out_sat)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference quantiser: floor((x + 2) / 4) clamped to [-64, 63].
    function automatic int qmodel(input logic [11:0] v, output bit clip);
        int s, r, q;
        s = $signed(v);
        r = s + 2;
        q = (r >= 0) ? r / 4 : -((-r + 3) / 4);
        clip = 1'b0;
        if (q > 63)  begin q = 63;  clip = 1'b1; end
        if (q < -64) begin q = -64; clip = 1'b1; end
        return q;
    endfunction

    // Behaviour of the stand-in classifier attached to x0/x1.
    function automatic logic cls(input logic [6:0] a, input logic [6:0] b);
        return a[2] ^ b[4] ^ a[0] ^ b[0];
    endfunction

    typedef struct { logic lab; logic sat; } res_t;
    res_t exp_q[$];
    int acc_cnt = 0;
    int pop_cnt = 0;
    logic [6:0] h0 [4];
    logic [6:0] h1 [4];

    // Monitor / scoreboard / classifier, all at the falling edge.
    always @(negedge clk) begin
        int q0, q1;
        bit c0, c1;
        res_t r;
        logic [6:0] a, b;
        if (!rst) begin
            label = 1'b0;
            for (int i = 0; i < 4; i++) begin h0[i] = '0; h1[i] = '0; end
        end else begin
            if (in_valid && in_ready) begin
                q0 = qmodel(in_x0, c0);
                q1 = qmodel(in_x1, c1);
                a = 7'(q0);
                b = 7'(q1);
                r.lab = cls(a, b);
                r.sat = c0 | c1;
                exp_q.push_back(r);
                acc_cnt++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    r = exp_q.pop_front();
                    check("out_label", 32'(out_label), 32'(r.lab));
                    check("out_sat", 32'(out_sat), 32'(r.sat));
                end
                pop_cnt++;
            end
            for (int i = 3; i > 0; i--) begin h0[i] = h0[i-1]; h1[i] = h1[i-1]; end
            h0[0] = x0;
            h1[0] = x1;
            label = cls(h0[3], h1[3]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] rnd_x();
        logic [11:0] ext [6];
        ext[0] = 12'h7FF; ext[1] = 12'h800; ext[2] = 12'h0FD;
        ext[3] = 12'hF01; ext[4] = 12'h0FE; ext[5] = 12'hEFD;
        if ($urandom_range(0, 3) == 0) return ext[$urandom_range(0, 5)];
        return 12'($urandom_range(0, 4095));
    endfunction

    task automatic wait_drain(input string tag, input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < budget) begin
            tick();
            k++;
        end
        check(tag, 32'(k < budget), 32'd1);
    endtask

    task automatic push_one(input string tag, input logic [11:0] a, input logic [11:0] b,
                            input logic [6:0] e0, input logic [6:0] e1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_x0 = a;
        in_x1 = b;
        tick();
        in_valid = 1'b0;
        check({tag, "_no_fallthrough"}, 32'(x0), 32'd0);
        tick();
        check({tag, "_x0"}, 32'(x0), 32'(e0));
        check({tag, "_x1"}, 32'(x1), 32'(e1));
        wait_drain({tag, "_drain"}, 50);
    endtask

    initial begin
        int acc0, pop0, seen;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_x0 = '0; in_x1 = '0;
        repeat (3) tick();
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_x0", 32'(x0), 0);
        check("rst_x1", 32'(x1), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_label", 32'(out_label), 0);
        check("rst_out_sat", 32'(out_sat), 0);
        rst = 1'b1;
        #1;
        check("in_ready_before_edge", 32'(in_ready), 0);
        tick();
        check("in_ready_first_edge", 32'(in_ready), 1);

        // Quantisation and saturation
        push_one("quant_pos", 12'h010, 12'h006, 7'd4, 7'd2);
        push_one("quant_neg", 12'hFFA, 12'hFFA, 7'h7F, 7'h7F);
        push_one("sat", 12'h7FF, 12'h806, 7'h3F, 7'h40);
        push_one("after_sat", 12'h020, 12'h000, 7'd8, 7'd0);

        // Back-to-back streaming
        out_ready = 1'b1;
        pop0 = pop_cnt;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_x0 = rnd_x();
            in_x1 = rnd_x();
            check("stream_in_ready", 32'(in_ready), 1);
            tick();
        end
        in_valid = 1'b0;
        wait_drain("stream_drain", 50);
        check("stream_count", 32'(pop_cnt - pop0), 10);

        // Backpressure: 4 buffered + 8 credits
        out_ready = 1'b0;
        acc0 = acc_cnt;
        pop0 = pop_cnt;
        for (int i = 0; i < 30; i++) begin
            in_valid = 1'b1;
            in_x0 = rnd_x();
            in_x1 = rnd_x();
            tick();
        end
        check("bp_accepted", 32'(acc_cnt - acc0), 12);
        check("bp_in_ready", 32'(in_ready), 0);
        check("bp_out_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        for (int i = 0; i < 100 && (acc_cnt - acc0) < 20; i++) begin
            in_valid = 1'b1;
            in_x0 = rnd_x();
            in_x1 = rnd_x();
            tick();
        end
        in_valid = 1'b0;
        wait_drain("bp_drain", 100);
        check("bp_total_accepted", 32'(acc_cnt - acc0), 20);
        check("bp_total_popped", 32'(pop_cnt - pop0), 20);

        // Credit boundary: 7 results queued + 1 in flight, pop in same cycle
        out_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            in_valid = 1'b1;
            in_x0 = 12'(12'h040 + k * 16);
            in_x1 = rnd_x();
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
        tick();
        check("limit_no_issue", 32'(x0), 0);
        tick();
        check("limit_resume_x0", 32'(x0), 48);
        wait_drain("limit_drain", 50);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_x0 = rnd_x();
            in_x1 = rnd_x();
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_drain("rand_drain", 200);

        // Reset mid-stream
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_x0 = 12'(12'h100 + k * 8);
            in_x1 = rnd_x();
            tick();
        end
        in_valid = 1'b0;
        check("pre_rst_out_valid", 32'(out_valid), 1);
        check("pre_rst_x0_nonzero", 32'(x0 != 7'd0), 1);
        rst = 1'b0;
        #1;
        exp_q.delete();
        check("mid_rst_in_ready", 32'(in_ready), 0);
        check("mid_rst_x0", 32'(x0), 0);
        check("mid_rst_x1", 32'(x1), 0);
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_out_label", 32'(out_label), 0);
        check("mid_rst_out_sat", 32'(out_sat), 0);
        repeat (2) tick();
        rst = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("post_rst_no_stale", 32'(seen), 0);
        pop0 = pop_cnt;
        push_one("post_rst", 12'h03C, 12'hFC4, 7'd15, 7'h71);
        check("post_rst_count", 32'(pop_cnt - pop0), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/svm_feeder.md
SVM_FEEDER -- requirements
Module: svm_feeder

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-003 SHALL have port in_valid, input, 1: upstream feature pair present.
REQ-004 SHALL have port in_ready, output, 1: feeder accepts pair this cycle.
REQ-005 SHALL have ports in_x0 and in_x1, input, 12 each: signed Q7.4 features.
REQ-006 SHALL have ports x0 and x1, output, 7 each: signed Q5.2 features to classifier, registered.
REQ-007 SHALL have port label, input, 1: classifier result.
REQ-008 SHALL have port out_valid, output, 1: result available downstream.
REQ-009 SHALL have port out_ready, input, 1: downstream accepts result.
REQ-010 SHALL have port out_label, output, 1: classified label.
REQ-011 SHALL have port out_sat, output, 1: either feature of this pair saturated during quantisation.
REQ-012 SHALL have fixed constants: input FIFO depth 4, result FIFO depth 8, classifier latency LAT 4 (issue edge to capture edge).

Function
REQ-013 Input handshake SHALL be: push when in_valid and in_ready at rising edge; in_ready = input FIFO not full; no push when full even if a pop occurs in the same cycle.
REQ-014 Quantisation SHALL be applied per feature at push: 13-bit sign-extend, add 2, arithmetic shift right 2, saturate to [-64, +63]; sat flag = OR of both features' clip events; stored with pair.
REQ-015 Issue condition SHALL be: input FIFO non-empty and (inflight + result count) < 8, using pre-edge counts; an out pop in the same cycle is not credited.
REQ-016 On issue SHALL: pop the input FIFO, load x0/x1 with the pair, shift a 1 with its sat flag into the LAT-stage in-flight pipe.
REQ-017 On no issue SHALL: load x0/x1 with 0 and shift a 0 into the in-flight pipe.
REQ-018 Entry pushed at edge E SHALL be issuable no earlier than edge E+1 (no fall-through).
REQ-019 When in-flight stage LAT holds 1 at edge E+LAT, SHALL sample label and push {label, sat} into the result FIFO; credit rule guarantees the FIFO is never full.
REQ-020 Output handshake SHALL be: out_valid = result FIFO non-empty; out_label/out_sat show head entry; pop when out_valid and out_ready; simultaneous push and pop allowed at any occupancy.
REQ-021 out_label/out_sat SHALL be stable while out_valid and not out_ready.
REQ-022 Results SHALL leave in input-acceptance order; no drop, duplication or reorder.
REQ-023 Sustained throughput SHALL be one pair per cycle when in_valid and out_ready are held high.
REQ-024 Pointers SHALL wrap modulo depth; occupancy counters SHALL never exceed depth or go negative.

Reset
REQ-025 While rst is low, SHALL asynchronously force: in_ready 0, x0 0, x1 0, out_valid 0, out_label 0, out_sat 0, both FIFOs empty, in-flight pipe cleared.
REQ-026 in_ready SHALL go high on the first rising edge after rst deasserts.
REQ-027 Reset mid-operation SHALL discard all buffered and in-flight pairs; no stale label SHALL appear afterwards.

Verification
REQ-028 Quantisation: push in_x0=0x010, in_x1=0x006 -> issued x0=7'sd4, x1=7'sd2, out_sat 0; push 0xFFA -> x=-1 (7'h7F).
REQ-029 Saturation: push in_x0=0x7FF, in_x1=0x806 -> x0=+63, x1=-64, out_sat 1 on that result only.
REQ-030 Latency/streaming: out_ready 1, push 10 pairs back-to-back -> first x0 update 1 edge after push, label captured 4 edges later, 10 results in order, in_ready never low.
REQ-031 Backpressure: out_ready 0, push 20 pairs -> exactly 8 results held, 12 accepted total (4 input FIFO + 8 credits), in_ready low; release out_ready -> all 12 drain in order, rest then accepted.
REQ-032 Boundary: result FIFO at 7 with 1 in flight and out pop same cycle -> no issue that cycle; issue resumes next cycle; no overflow.
REQ-033 Reset mid-stream: assert rst with 3 in flight and 5 buffered -> all outputs 0 immediately; after release no out_valid until new pairs pushed and LAT elapsed.
